// File: rtl/conv_pkg.sv
// ============================================================================
// Module  : conv_pkg
// Brief   : Shared constants, address fields and state encoding for conv_mem_host
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package conv_pkg;

    localparam int DATA_W    = 13;
    localparam int IMG_DEPTH = 4096;
    localparam int L1_DEPTH  = 1024;

    localparam int IMG_AW = $clog2(IMG_DEPTH);
    localparam int L1_AW  = $clog2(L1_DEPTH);

    // Image address layout: row = addr[11:6], col = addr[5:0]
    localparam int ROW_MSB = 11;
    localparam int ROW_LSB = 6;
    localparam int COL_MSB = 5;
    localparam int COL_LSB = 0;

    localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_DEPTH - 1);
    localparam logic [L1_AW-1:0]  L1_LAST  = L1_AW'(L1_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_HANDOFF = 3'd1,
        ST_RUN     = 3'd2,
        ST_DUMP    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic logic l1_addr_ok(input logic [IMG_AW-1:0] addr);
        return addr[IMG_AW-1:L1_AW] == '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_mem_bank.sv
// ============================================================================
// Module  : conv_mem_bank
// Brief   : Word memory, one synchronous write port, one asynchronous read port
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module conv_mem_bank #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 13,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/conv_mem_host.sv
// ============================================================================
// Module  : conv_mem_host
// Brief   : Image loader, layer memories and layer-1 dump for the conv engine
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module conv_mem_host
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              img_valid,
    input  logic [DATA_W-1:0] img_data,
    output logic              img_ready,
    output logic              ready,
    input  logic              busy,
    input  logic [IMG_AW-1:0] iaddr,
    output logic [DATA_W-1:0] idata,
    input  logic              cwr,
    input  logic [IMG_AW-1:0] caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              crd,
    input  logic [IMG_AW-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_rd,
    input  logic              csel,
    output logic              dump_valid,
    output logic [L1_AW-1:0]  dump_addr,
    output logic [DATA_W-1:0] dump_data,
    input  logic              dump_ready,
    output logic              done,
    output logic              addr_err,
    output logic [31:0]       run_cycles
);

    state_e             state_q, state_d;
    logic               img_ready_q, img_ready_d;
    logic [IMG_AW-1:0]  load_cnt_q, load_cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        run_cycles_q, run_cycles_d;
    logic [L1_AW-1:0]   dump_addr_q, dump_addr_d;
    logic               addr_err_q, addr_err_d;

    logic               w_load_acc;
    logic               w_in_run;
    logic               w_l0_we;
    logic               w_l1_wr_req;
    logic               w_l1_we;
    logic               w_dump_view;
    logic               w_dump_hs;
    logic [L1_AW-1:0]   w_l1_raddr;
    logic [DATA_W-1:0]  w_l0_rdata;
    logic [DATA_W-1:0]  w_l1_rdata;

    assign w_load_acc  = img_valid & img_ready_q;
    assign w_in_run    = (state_q == ST_RUN);
    assign w_l0_we     = w_in_run & cwr & ~csel;
    assign w_l1_wr_req = w_in_run & cwr & csel;
    assign w_l1_we     = w_l1_wr_req & l1_addr_ok(caddr_wr);
    assign w_dump_view = (state_q == ST_DUMP) || (state_q == ST_DONE);
    assign w_dump_hs   = (state_q == ST_DUMP) & dump_ready;

    // Layer 1 has a single read port; once the engine has finished, the dump owns it.
    assign w_l1_raddr  = w_dump_view ? dump_addr_q : caddr_rd[L1_AW-1:0];

    conv_mem_bank #(.DEPTH(IMG_DEPTH), .WIDTH(DATA_W)) u_img_bank (
        .clk   (clk),
        .we    (w_load_acc),
        .waddr (load_cnt_q),
        .wdata (img_data),
        .raddr (iaddr),
        .rdata (idata)
    );

    conv_mem_bank #(.DEPTH(IMG_DEPTH), .WIDTH(DATA_W)) u_l0_bank (
        .clk   (clk),
        .we    (w_l0_we),
        .waddr (caddr_wr),
        .wdata (cdata_wr),
        .raddr (caddr_rd),
        .rdata (w_l0_rdata)
    );

    conv_mem_bank #(.DEPTH(L1_DEPTH), .WIDTH(DATA_W)) u_l1_bank (
        .clk   (clk),
        .we    (w_l1_we),
        .waddr (caddr_wr[L1_AW-1:0]),
        .wdata (cdata_wr),
        .raddr (w_l1_raddr),
        .rdata (w_l1_rdata)
    );

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        run_cycles_d = run_cycles_q;
        dump_addr_d  = dump_addr_q;
        busy_d       = busy;
        addr_err_d   = addr_err_q | (w_l1_wr_req & ~l1_addr_ok(caddr_wr));

        case (state_q)
            ST_LOAD: begin
                if (w_load_acc) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == IMG_LAST) begin
                        state_d = ST_HANDOFF;
                    end
                end
            end
            ST_HANDOFF: begin
                if (busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_cycles_q != '1) begin
                    run_cycles_d = run_cycles_q + 32'd1;
                end
                if (busy_q && !busy) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (w_dump_hs) begin
                    if (dump_addr_q == L1_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        dump_addr_d = dump_addr_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        img_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            img_ready_q  <= 1'b0;
            load_cnt_q   <= '0;
            busy_q       <= 1'b0;
            run_cycles_q <= '0;
            dump_addr_q  <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            img_ready_q  <= img_ready_d;
            load_cnt_q   <= load_cnt_d;
            busy_q       <= busy_d;
            run_cycles_q <= run_cycles_d;
            dump_addr_q  <= dump_addr_d;
            addr_err_q   <= addr_err_d;
        end
    end

    always_comb begin
        cdata_rd = '0;
        if (crd) begin
            cdata_rd = csel ? w_l1_rdata : w_l0_rdata;
        end
    end

    assign img_ready  = img_ready_q;
    assign ready      = (state_q == ST_HANDOFF);
    assign dump_valid = (state_q == ST_DUMP);
    assign done       = (state_q == ST_DONE);
    assign dump_addr  = dump_addr_q;
    assign dump_data  = w_dump_view ? w_l1_rdata : '0;
    assign addr_err   = addr_err_q;
    assign run_cycles = run_cycles_q;

endmodule

`default_nettype wire

// File: doc/conv_mem_host.md
Name: conv_mem_host

Overview:
- System-side responder for the convolution engine's memory interface.
- Accepts a 64x64 13-bit image over a valid/ready stream and stores it.
- Raises ready, then serves the engine's image reads, layer-0 reads/writes and layer-1 writes.
- When the engine drops busy, streams the 1024 layer-1 results out over a valid/ready dump port.

Parameters:
- DATA_W, 13, pixel/result word width (signed two's complement, 4 fractional bits)
- IMG_DEPTH, 4096, image and layer-0 depth (12-bit address, row = addr[11:6], col = addr[5:0])
- L1_DEPTH, 1024, layer-1 depth (10-bit address)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- img_valid  in  1  load-stream pixel valid
- img_data  in  13  load-stream pixel, raster order
- img_ready  out  1  high while accepting image pixels
- ready  out  1  image loaded, engine may start
- busy  in  1  engine busy
- iaddr  in  12  image read address
- idata  out  13  image read data
- cwr  in  1  write strobe
- caddr_wr  in  12  write address
- cdata_wr  in  13  write data
- crd  in  1  read strobe
- caddr_rd  in  12  read address
- cdata_rd  out  13  read data
- csel  in  1  bank select: 0 = layer 0, 1 = layer 1
- dump_valid  out  1  dump word valid
- dump_addr  out  10  layer-1 address of dump word
- dump_data  out  13  layer-1 word
- dump_ready  in  1  dump sink accepts word
- done  out  1  dump complete
- addr_err  out  1  sticky: out-of-range layer-1 write seen
- run_cycles  out  32  clock cycles spent in RUN

Behaviour:
- Reset values: img_ready=0, ready=0, dump_valid=0, dump_addr=0, done=0, addr_err=0, run_cycles=0, all counters 0.
- Reset does not clear the memory arrays. Reset mid-operation returns to LOAD from any state.
- States: LOAD, HANDOFF, RUN, DUMP, DONE.
- LOAD:
  - img_ready=1 from the first cycle after reset release.
  - Each cycle with img_valid&img_ready writes img_mem[load_cnt] and increments load_cnt.
  - The 4096th accepted pixel moves to HANDOFF; img_ready=0 in the following cycle.
- HANDOFF:
  - ready=1.
  - When busy is sampled 1, ready=0 in the next cycle and move to RUN.
  - busy=1 while in LOAD is ignored.
- RUN:
  - run_cycles increments every cycle; it saturates at 2^32-1.
  - Detect busy 1->0 using the registered busy_q. On the fall, move to DUMP.
- Image read: idata = img_mem[iaddr], combinational (asynchronous read, zero latency). Valid in every state.
- Layer read:
  - cdata_rd is combinational, zero latency.
  - crd=0 -> 0.
  - crd=1, csel=0 -> l0_mem[caddr_rd].
  - crd=1, csel=1 -> l1_mem[caddr_rd[9:0]].
- Layer write, synchronous, only in RUN:
  - cwr&!csel -> l0_mem[caddr_wr] <= cdata_wr.
  - cwr&csel with caddr_wr[11:10]==0 -> l1_mem[caddr_wr[9:0]] <= cdata_wr.
  - cwr&csel with caddr_wr[11:10]!=0 -> no write; addr_err<=1 (sticky until reset).
  - cwr outside RUN is ignored.
- Same-cycle read and write of the same address: cdata_rd returns the old contents; the new value is visible the next cycle.
- crd and cwr both high in the same cycle is legal; the two operations are independent.
- DUMP:
  - dump_valid=1 and dump_data = l1_mem[dump_addr].
  - dump_addr and dump_data hold stable while dump_ready=0.
  - On dump_valid&dump_ready, dump_addr increments.
  - The handshake at dump_addr=1023 moves to DONE; dump_valid=0 in the next cycle. dump_addr does not wrap.
- DONE: done=1, all other outputs static. Only reset leaves DONE.

Decomposition:
- Shared package conv_pkg:
  - DATA_W, IMG_DEPTH, L1_DEPTH.
  - Address widths 12/10 and row/column field positions.
  - State enum for LOAD/HANDOFF/RUN/DUMP/DONE.
- One natural sub-module: conv_mem_bank.
  - Parameterised depth/width, one synchronous write port, one asynchronous read port.
  - Instantiated three times: image, layer 0, layer 1.
  - The image bank's write port is driven by the loader.

Test Plan:
- Load pixels img_data=i[12:0] for i=0..4095 with img_valid toggling every other cycle.
  - Required: img_ready drops after exactly 4096 accepts.
  - Required: ready=1 one cycle later.
  - Required: iaddr=0x0FFF -> idata=0x0FFF in the same cycle.
- In HANDOFF, raise busy at cycle T -> ready=0 at T+1, state RUN; run_cycles counts from 0.
- In RUN, cwr=1, csel=0, caddr_wr=0x123, cdata_wr=0x0A5.
  - Same cycle with crd=1, caddr_rd=0x123: returns the old value.
  - Next cycle: cdata_rd=0x0A5.
  - crd=0: cdata_rd=0.
- In RUN, cwr=1, csel=1, caddr_wr=0x400 -> addr_err=1, l1_mem unchanged.
  - Then caddr_wr=0x3FF, cdata_wr=0x1F0 -> the dump at address 1023 yields 0x1F0.
- Drop busy, hold dump_ready=0 for 5 cycles, then pulse it randomly.
  - Required: dump_addr/dump_data stable while dump_ready=0.
  - Required: 1024 words in order, no duplicates.
  - Required: done=1 after the last handshake; dump_valid=0.
- Assert reset during DUMP at dump_addr=500.
  - Required: all outputs return to reset values asynchronously; state LOAD; img_ready=1 after release.
  - Required: previously loaded image still readable via iaddr.
